order_tx_scheduler: RTL
=======================

Name: order_tx_scheduler

Overview:
- Shares the single UART transmit byte interface between two requesters: trade orders (requester 0, from the arbitrage trade logic) and status/acks (requester 1).
- Frames each accepted 32-bit payload as header 0xAA, four payload bytes MSB first, then footer 0x55. This is the same framing the receive-side packet parser expects.
- Sits between the trade logic and the uart_tx instance. It sequences byte issue against the transmitter's busy flag and enforces an inter-packet gap.

Parameters:
- GAP_CYCLES, 16: idle clk cycles after the footer byte completes, before the next grant.
- CNT_W, 16: width of the sent-packet counter.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a payload
- req0_data  in  32  requester 0 payload, byte 3 sent first
- req0_ready  out  1  one-cycle accept pulse to requester 0
- req1_valid  in  1  requester 1 has a payload
- req1_data  in  32  requester 1 payload
- req1_ready  out  1  one-cycle accept pulse to requester 1
- uart_tx_busy  in  1  transmitter busy; rises the cycle after uart_tx_en, falls when the stop bit ends
- uart_tx_en  out  1  one-cycle byte-start strobe
- uart_tx_data  out  8  byte to send; valid while uart_tx_en=1
- grant_id  out  1  requester owning the current or last frame
- sched_busy  out  1  high from accept until the GAP phase ends
- packets_sent  out  CNT_W  count of completed frames

Behaviour:
- Reset (async, rst=1):
  - Forces IDLE.
  - All outputs go to 0: ready pulses, uart_tx_en, uart_tx_data, grant_id, sched_busy, packets_sent.
  - Internal last_grant resets to 1, so requester 0 wins the first contention.
  - Reset mid-frame aborts the frame immediately; no further bytes are issued.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP.
- IDLE:
  - If any valid is high, arbitrate round-robin. The winner is the requester not equal to last_grant when both are valid, otherwise the single valid one.
  - Pulse the winner's ready for exactly 1 cycle.
  - Latch its data into a 32-bit shadow register. Later changes to req*_data or valid have no effect on the frame.
  - Set grant_id and last_grant to the winner, set sched_busy=1, set byte_idx=0, and go to ISSUE.
- Requesters hold valid until ready. A requester dropping valid before grant is simply not served.
- Byte sequence by byte_idx:
  - 0 = 0xAA
  - 1..4 = shadow[31:24], [23:16], [15:8], [7:0]
  - 5 = 0x55
- ISSUE:
  - Entered only when uart_tx_busy=0; if busy is high, stay in ISSUE without strobing.
  - Drive uart_tx_data and pulse uart_tx_en for 1 cycle, then go to WAIT_HI.
- WAIT_HI: wait for uart_tx_busy=1, then go to WAIT_LO. uart_tx_en stays 0.
- WAIT_LO: wait for uart_tx_busy=0.
  - If byte_idx is the last byte: increment packets_sent (wraps all-ones to 0), load the gap counter with GAP_CYCLES, and go to GAP.
  - Otherwise: byte_idx+1 and go to ISSUE.
- GAP:
  - Decrement the counter each cycle; at 0, clear sched_busy and go to IDLE.
  - With GAP_CYCLES=0, GAP lasts exactly 1 cycle.
  - Requests arriving during GAP wait, with no ready pulse.
- Latency: from req valid in IDLE, ready is on the next clk edge; the first uart_tx_en comes 1 cycle after ready.
- Exactly one ready pulse per frame. uart_tx_en is never high in two consecutive cycles.
- Simultaneous valid on both requesters with a continuous load gives alternating grants 0,1,0,1.

Optional Feature:
- Macro ORDER_TX_CHECKSUM_EN.
- Defined:
  - A checksum byte (XOR of the four payload bytes) is inserted at byte_idx 5.
  - The footer 0x55 moves to byte_idx 6, for 7 bytes per frame.
- Undefined: 6 bytes per frame as above, and no checksum logic is synthesised.

Test Plan:
- Single request: req0_data=0x12345678 with a TX model (busy 1 cycle after en, 10 cycles long) -> bytes AA 12 34 56 78 55; one req0_ready pulse; packets_sent=1; sched_busy low GAP_CYCLES+1 cycles after the last busy fall.
- Contention: both valid continuously from reset, req0=0x00000001, req1=0x00000002 -> frames in order req0, req1, req0; grant_id toggles; no interleaved bytes.
- Data change after accept: change req1_data to 0xFFFFFFFF the cycle after req1_ready -> the frame still carries the originally latched payload.
- Reset mid-frame: assert rst during byte 2 -> uart_tx_en=0 immediately; packets_sent=0; after release, the next request produces a full fresh frame starting with AA.
- Counter wrap with CNT_W=2: send 4 frames -> packets_sent sequence 1,2,3,0.
- With ORDER_TX_CHECKSUM_EN and payload 0x0F0F00FF -> bytes AA 0F 0F 00 FF FF 55.

Source files
------------

// File: rtl/order_tx_scheduler.sv
// order_tx_scheduler
//   Shares one UART transmit byte interface between trade orders (requester 0)
//   and status/acks (requester 1). Each accepted 32-bit payload is framed as
//   0xAA, payload bytes MSB first, then 0x55. The block issues one byte at a
//   time against the transmitter busy flag and then holds an idle gap before
//   the next grant.
//
//   Optional build macro ORDER_TX_CHECKSUM_EN: inserts an XOR checksum of the
//   four payload bytes ahead of the footer (7 bytes per frame instead of 6).
//
// Parameters
//   GAP_CYCLES   idle cycles after the footer byte completes, before the next grant
//   CNT_W        width of the sent-packet counter (wraps)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/data/ready    requester 0 handshake (ready = one-cycle accept pulse)
//   req1_valid/data/ready    requester 1 handshake
//   uart_tx_busy             transmitter busy flag
//   uart_tx_en/uart_tx_data  one-cycle byte strobe and the byte to send
//   grant_id                 requester owning the current or last frame
//   sched_busy               high from accept until the gap ends
//   packets_sent             count of completed frames
module order_tx_scheduler #(
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [31:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    input  logic             uart_tx_busy,
    output logic             uart_tx_en,
    output logic [7:0]       uart_tx_data,
    output logic             grant_id,
    output logic             sched_busy,
    output logic [CNT_W-1:0] packets_sent
);

    localparam int unsigned GAP_W = (GAP_CYCLES >= 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned IDX_W = 3;
`ifdef ORDER_TX_CHECKSUM_EN
    localparam int unsigned LAST_IDX = 6;
`else
    localparam int unsigned LAST_IDX = 5;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_id_q, grant_id_d;
    logic               sched_busy_q, sched_busy_d;
    logic [CNT_W-1:0]   packets_sent_q, packets_sent_d;
    logic               req0_ready_q, req0_ready_d;
    logic               req1_ready_q, req1_ready_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [7:0]         tx_byte_c;
    logic               winner_c;

    // Byte to transmit for the current frame position
    always_comb begin
        tx_byte_c = 8'h00;
        case (byte_idx_q)
            IDX_W'(0): tx_byte_c = 8'hAA;
            IDX_W'(1): tx_byte_c = shadow_q[31:24];
            IDX_W'(2): tx_byte_c = shadow_q[23:16];
            IDX_W'(3): tx_byte_c = shadow_q[15:8];
            IDX_W'(4): tx_byte_c = shadow_q[7:0];
`ifdef ORDER_TX_CHECKSUM_EN
            IDX_W'(5): tx_byte_c = shadow_q[31:24] ^ shadow_q[23:16]
                                 ^ shadow_q[15:8]  ^ shadow_q[7:0];
            IDX_W'(6): tx_byte_c = 8'h55;
`else
            IDX_W'(5): tx_byte_c = 8'h55;
`endif
            default:   tx_byte_c = 8'h00;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            shadow_q       <= 32'h0;
            byte_idx_q     <= '0;
            gap_cnt_q      <= '0;
            last_grant_q   <= 1'b1;
            grant_id_q     <= 1'b0;
            sched_busy_q   <= 1'b0;
            packets_sent_q <= '0;
            req0_ready_q   <= 1'b0;
            req1_ready_q   <= 1'b0;
            tx_en_q        <= 1'b0;
            tx_data_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            byte_idx_q     <= byte_idx_d;
            gap_cnt_q      <= gap_cnt_d;
            last_grant_q   <= last_grant_d;
            grant_id_q     <= grant_id_d;
            sched_busy_q   <= sched_busy_d;
            packets_sent_q <= packets_sent_d;
            req0_ready_q   <= req0_ready_d;
            req1_ready_q   <= req1_ready_d;
            tx_en_q        <= tx_en_d;
            tx_data_q      <= tx_data_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        byte_idx_d     = byte_idx_q;
        gap_cnt_d      = gap_cnt_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id_q;
        sched_busy_d   = sched_busy_q;
        packets_sent_d = packets_sent_q;
        req0_ready_d   = 1'b0;
        req1_ready_d   = 1'b0;
        tx_en_d        = 1'b0;
        tx_data_d      = tx_data_q;
        winner_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // Round-robin: on contention the requester not served last wins
                    winner_c       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    req0_ready_d   = ~winner_c;
                    req1_ready_d   = winner_c;
                    shadow_d       = winner_c ? req1_data : req0_data;
                    grant_id_d     = winner_c;
                    last_grant_d   = winner_c;
                    sched_busy_d   = 1'b1;
                    byte_idx_d     = '0;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!uart_tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = tx_byte_c;
                    state_d   = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!uart_tx_busy) begin
                    if (byte_idx_q == IDX_W'(LAST_IDX)) begin
                        packets_sent_d = packets_sent_q + CNT_W'(1);
                        gap_cnt_d      = GAP_W'(GAP_CYCLES);
                        state_d        = ST_GAP;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_GAP: begin
                // Counter reaching zero ends the gap, so GAP lasts GAP_CYCLES+1 cycles
                if (gap_cnt_q == GAP_W'(0)) begin
                    sched_busy_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req0_ready   = req0_ready_q;
    assign req1_ready   = req1_ready_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign grant_id     = grant_id_q;
    assign sched_busy   = sched_busy_q;
    assign packets_sent = packets_sent_q;

endmodule
